uart_rx_fifo: RTL

//  Receive buffer directly downstream of the UART receiver. Captures each completed

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_fifo_mem.sv | 26 ++
 rtl/uart_rx_fifo.sv | 96 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, default RX buffer depth, rx/tx FSM states.
package uart_pkg;

    localparam int UART_DATA_SIZE     = 8;
    localparam int UART_RX_FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } uart_rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } uart_tx_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// Storage array for the RX FIFO: synchronous write, asynchronous (show-ahead) read.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_SIZE,
    parameter int DEPTH  = UART_RX_FIFO_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: show-ahead FIFO with ready/valid output, sticky overrun
// and frame-error status, and a fill-level interrupt.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_SIZE,
    parameter int DEPTH  = UART_RX_FIFO_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] rx_data_i,
    input  logic              rx_valid_i,
    input  logic              rx_frame_err_i,
    input  logic              flush_i,
    input  logic              clr_err_i,
    input  logic [ADDR_W:0]   thresh_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [ADDR_W:0]   count_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              overrun_o,
    output logic              frame_err_o,
    output logic              irq_o
);

    logic [ADDR_W:0] wr_ptr, rd_ptr, count_q;
    logic [ADDR_W:0] wr_ptr_d, rd_ptr_d, count_d;
    logic            overrun_q, frame_err_q;
    logic            good_byte, pop, push, ovr_evt;

    // Status decoded straight from the pointers so it tracks them exactly.
    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign valid_o = !empty_o;

    // A frame error on the same cycle as a valid pulse drops the byte.
    assign good_byte = rx_valid_i && !rx_frame_err_i && !flush_i;
    assign pop       = valid_o && ready_i && !flush_i;
    assign push      = good_byte && (!full_o || pop);
    assign ovr_evt   = good_byte && full_o && !pop;

    // Next pointer / count state; flush collapses the FIFO and beats push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr;
        rd_ptr_d = rd_ptr;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = wr_ptr;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    // Pointer, count and sticky flag registers; a set event beats clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr_d;
            rd_ptr      <= rd_ptr_d;
            count_q     <= count_d;
            overrun_q   <= (overrun_q   && !clr_err_i) || ovr_evt;
            frame_err_q <= (frame_err_q && !clr_err_i) || rx_frame_err_i;
        end
    end

    assign count_o     = count_q;
    assign overrun_o   = overrun_q;
    assign frame_err_o = frame_err_q;
    assign irq_o       = (thresh_i != '0) && (count_q >= thresh_i);

    uart_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (rx_data_i),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (data_o)
    );

endmodule
